// File: rtl/game_pkg.sv
// Shared game state encoding and BCD timer helpers.
// Used by the sequencer, play timer and display.
package game_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8,
    ST_HELP     = 4'd9
  } game_state_e;

  function automatic logic [12:0] bcd_to_sec(
    input logic [15:0] bcd
  );
    logic [12:0] m;
    m = 13'(bcd[15:12]) * 13'd10 + 13'(bcd[11:8]);
    return m * 13'd60
         + 13'(bcd[7:4]) * 13'd10
         + 13'(bcd[3:0]);
  endfunction

  function automatic logic bcd_ok(
    input logic [15:0] bcd
  );
    return (bcd[15:12] <= 4'd9)
        && (bcd[11:8]  <= 4'd9)
        && (bcd[7:4]   <= 4'd9)
        && (bcd[3:0]   <= 4'd9);
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Button, stage-result and timer inputs plus state outputs
// of the game sequencer.
interface game_state_ctrl_if;
  import game_pkg::*;

  logic               btn_start;
  logic               btn_help;
  logic               btn_back;
  logic               stage_clear;
  logic               stage_fail;
  logic [15:0]        timer_bcd;
  logic [STATE_W-1:0] state;
  logic [1:0]         stage_num;
  logic               state_enter;

  modport master (
    output btn_start, btn_help, btn_back,
    output stage_clear, stage_fail, timer_bcd,
    input  state, stage_num, state_enter
  );

  modport slave (
    input  btn_start, btn_help, btn_back,
    input  stage_clear, stage_fail, timer_bcd,
    output state, stage_num, state_enter
  );

endinterface

// File: rtl/sec_tick.sv
// CLK_HZ prescaler; one-cycle tick per second.
// clr marks the current cycle as cycle 0 of a new second.
module sec_tick #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_eff;

  assign cnt_eff = clr ? '0 : cnt_q;
  assign tick    = (cnt_eff == CW'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (tick)
      cnt_q <= '0;
    else
      cnt_q <= cnt_eff + CW'(1);
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: title/help/staff, three stages with success screens.
// GAME_TIME_LIMIT_EN adds a per-stage time limit from timer_bcd.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int SUCCESS_SEC = 3,
  parameter int LIMIT_SEC   = 300
) (
  input logic               clk,
  input logic               rst,
  game_state_ctrl_if.slave  bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [1:0]         num_q, num_d;
  logic               enter_q;
  logic               tick;
  logic [3:0]         sec_q, sec_eff;
  logic               auto_adv;
  logic               expire;
  logic               p_start, p_help, p_back;
  logic               e_clear, e_fail, e_exp, e_abort;

  sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (enter_q),
    .tick (tick)
  );

  assign sec_eff  = enter_q ? 4'd0 : sec_q;
  assign auto_adv = tick && (sec_eff == 4'(SUCCESS_SEC - 1));

  always_ff @(posedge clk) begin
    if (rst)
      sec_q <= 4'd0;
    else if (tick)
      sec_q <= sec_eff + 4'd1;
    else
      sec_q <= sec_eff;
  end

`ifdef GAME_TIME_LIMIT_EN
  logic [12:0] secs_q;
  logic        secs_ok_q;
  logic        enter_d1_q;
  logic        in_stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      secs_q     <= 13'd0;
      secs_ok_q  <= 1'b0;
      enter_d1_q <= 1'b0;
    end else begin
      secs_q     <= bcd_to_sec(bus.timer_bcd);
      secs_ok_q  <= bcd_ok(bus.timer_bcd);
      enter_d1_q <= enter_q;
    end
  end

  assign in_stage = (state_q == ST_STAGE1)
                 || (state_q == ST_STAGE2)
                 || (state_q == ST_STAGE3);

  // timer_bcd lags stage entry; ignore it for two cycles
  assign expire = in_stage && !enter_q && !enter_d1_q
               && secs_ok_q && (secs_q >= 13'(LIMIT_SEC));
`else
  logic unused_bcd;
  assign unused_bcd = ^bus.timer_bcd;
  assign expire     = 1'b0;
`endif

  assign p_start = bus.btn_start;
  assign p_help  = bus.btn_help && !bus.btn_start;
  assign p_back  = bus.btn_back && !bus.btn_start
                && !bus.btn_help;

  assign e_clear = bus.stage_clear;
  assign e_fail  = bus.stage_fail && !e_clear;
  assign e_exp   = expire && !e_clear && !bus.stage_fail;
  assign e_abort = p_back && !e_clear && !bus.stage_fail
                && !expire;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    case (state_q)
      ST_TITLE: begin
        unique case (1'b1)
          p_start: begin
            state_d = ST_STAGE1;
            num_d   = 2'd1;
          end
          p_help:  state_d = ST_HELP;
          p_back:  state_d = ST_STAFF;
          default: ;
        endcase
      end
      ST_STAFF: begin
        if (p_start || p_help || p_back)
          state_d = ST_TITLE;
      end
      ST_HELP: begin
        if (p_help || p_back)
          state_d = ST_TITLE;
      end
      ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
        unique case (1'b1)
          e_clear: state_d = state_q + 4'd1;
          e_fail:  state_d = ST_FAIL;
          e_exp:   state_d = ST_FAIL;
          e_abort: state_d = ST_TITLE;
          default: ;
        endcase
      end
      ST_SUCCESS1, ST_SUCCESS2: begin
        if (p_start || auto_adv) begin
          state_d = state_q + 4'd1;
          num_d   = num_q + 2'd1;
        end
      end
      ST_SUCCESS3: begin
        if (p_start || p_back)
          state_d = ST_TITLE;
      end
      ST_FAIL: begin
        unique case (1'b1)
          p_start: state_d = {1'b0, num_q, 1'b0};
          p_back:  state_d = ST_TITLE;
          default: ;
        endcase
      end
      default: begin
        state_d = ST_TITLE;
        num_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_TITLE;
      num_q   <= 2'd0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      enter_q <= (state_d != state_q);
    end
  end

  assign bus.state       = state_q;
  assign bus.stage_num   = num_q;
  assign bus.state_enter = enter_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed plus randomized bench for game_state_ctrl.
// Build with GAME_TIME_LIMIT_EN to cover the time limit.
module tb_game_state_ctrl;

  localparam int CLK_HZ      = 10;
  localparam int SUCCESS_SEC = 3;
  localparam int LIMIT_SEC   = 65;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  game_state_ctrl_if bus ();

  game_state_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .SUCCESS_SEC (SUCCESS_SEC),
    .LIMIT_SEC   (LIMIT_SEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: spec state codes as plain ints
  int ms, mn, me, age;
  logic [15:0] prev_bcd;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, s, h, b, c, f);
    rst             = r;
    bus.btn_start   = s;
    bus.btn_help    = h;
    bus.btn_back    = b;
    bus.stage_clear = c;
    bus.stage_fail  = f;
    @(negedge clk);
    rst             = 1'b0;
    bus.btn_start   = 1'b0;
    bus.btn_help    = 1'b0;
    bus.btn_back    = 1'b0;
    bus.stage_clear = 1'b0;
    bus.stage_fail  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  function automatic int bcd_secs(input logic [15:0] v);
    return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60
         + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit bcd_valid(input logic [15:0] v);
    return v[15:12] < 10 && v[11:8] < 10
        && v[7:4] < 10 && v[3:0] < 10;
  endfunction

  task automatic model_step(input bit r, s, h, b, c, f);
    int ns, nn;
    bit ph, pb, lim;
    ns  = ms;
    nn  = mn;
    ph  = h && !s;
    pb  = b && !s && !h;
    lim = 1'b0;
`ifdef GAME_TIME_LIMIT_EN
    lim = age >= 2 && bcd_valid(prev_bcd)
       && bcd_secs(prev_bcd) >= LIMIT_SEC;
`endif
    if (r) begin
      ns = 0;
      nn = 0;
    end else begin
      case (ms)
        0: if (s) begin ns = 2; nn = 1; end
           else if (ph) ns = 9;
           else if (pb) ns = 1;
        1: if (s || ph || pb) ns = 0;
        9: if (ph || pb) ns = 0;
        2, 4, 6:
           if (c) ns = ms + 1;
           else if (f || lim) ns = 8;
           else if (pb) ns = 0;
        3, 5:
           if (s || age + 1 == SUCCESS_SEC * CLK_HZ) begin
             ns = ms + 1;
             nn = mn + 1;
           end
        7: if (s || pb) ns = 0;
        8: if (s) ns = 2 * mn;
           else if (pb) ns = 0;
        default: begin ns = 0; nn = 0; end
      endcase
    end
    me  = (!r && ns != ms) ? 1 : 0;
    age = (r || ns != ms) ? 0 : age + 1;
    ms  = ns;
    mn  = nn;
  endtask

  initial begin
    logic [15:0] pick [6];
    bit r, s, h, b, c, f;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.btn_start = 0; bus.btn_help = 0; bus.btn_back = 0;
    bus.stage_clear = 0; bus.stage_fail = 0;
    bus.timer_bcd = 16'h0000;

    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_num", bus.stage_num, 0);
    chk("rst_enter", bus.state_enter, 0);

    cyc(0, 1, 0, 0, 0, 0);
    chk("start_state", bus.state, 2);
    chk("start_num", bus.stage_num, 1);
    chk("start_enter", bus.state_enter, 1);
    idle(1);
    chk("enter_once", bus.state_enter, 0);

    cyc(0, 0, 0, 0, 1, 1);
    chk("clr_fail_same", bus.state, 3);
    idle(29);
    chk("succ1_hold29", bus.state, 3);
    idle(1);
    chk("succ1_auto30", bus.state, 4);
    chk("succ1_num", bus.stage_num, 2);
    chk("succ1_enter", bus.state_enter, 1);

    idle(2);
    cyc(0, 0, 0, 0, 0, 1);
    chk("stage2_fail", bus.state, 8);
    cyc(0, 1, 0, 0, 0, 0);
    chk("retry_state", bus.state, 4);
    chk("retry_num", bus.stage_num, 2);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("fail_back", bus.state, 0);

    cyc(0, 0, 1, 1, 0, 0);
    chk("help_prio", bus.state, 9);
    cyc(0, 1, 0, 0, 0, 0);
    chk("help_start_ign", bus.state, 9);
    cyc(0, 0, 0, 1, 0, 0);
    chk("help_back", bus.state, 0);

`ifdef GAME_TIME_LIMIT_EN
    bus.timer_bcd = 16'h0105;
    cyc(0, 1, 0, 0, 0, 0);
    idle(1);
    chk("lim_blank1", bus.state, 2);
    idle(1);
    chk("lim_blank2", bus.state, 2);
    idle(1);
    chk("lim_after_blank", bus.state, 8);
    cyc(0, 0, 0, 1, 0, 0);
    bus.timer_bcd = 16'h0104;
    cyc(0, 1, 0, 0, 0, 0);
    idle(5);
    chk("lim_64s", bus.state, 2);
    bus.timer_bcd = 16'h0105;
    idle(1);
    chk("lim_65s_lat", bus.state, 2);
    idle(1);
    chk("lim_65s", bus.state, 8);
    cyc(0, 0, 0, 1, 0, 0);
    bus.timer_bcd = 16'h00AA;
    cyc(0, 1, 0, 0, 0, 0);
    idle(6);
    chk("lim_nonbcd", bus.state, 2);
    cyc(0, 0, 0, 1, 0, 0);
`else
    bus.timer_bcd = 16'h0105;
    cyc(0, 1, 0, 0, 0, 0);
    idle(6);
    chk("nolim_stage", bus.state, 2);
    cyc(0, 0, 0, 1, 0, 0);
`endif
    bus.timer_bcd = 16'h0000;
    chk("abort_title", bus.state, 0);

    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("reach_succ2", bus.state, 5);
    chk("reach_succ2_num", bus.stage_num, 2);
    cyc(1, 1, 0, 0, 0, 0);
    chk("rst_succ2_state", bus.state, 0);
    chk("rst_succ2_num", bus.stage_num, 0);

    cyc(0, 1, 0, 0, 0, 0);
    chk("pre_force", bus.state, 2);
    force dut.state_q = 4'd12;
    @(posedge clk);
    #1;
    release dut.state_q;
    @(negedge clk);
    idle(1);
    chk("illegal_state", bus.state, 0);
    chk("illegal_num", bus.stage_num, 0);

    pick[0] = 16'h0000; pick[1] = 16'h0104;
    pick[2] = 16'h0105; pick[3] = 16'h0200;
    pick[4] = 16'h00AA; pick[5] = 16'h0030;
    cyc(1, 0, 0, 0, 0, 0);
    ms = 0; mn = 0; me = 0; age = 0;
    prev_bcd = bus.timer_bcd;
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0)
        bus.timer_bcd = (i % 64 == 0)
          ? 16'($urandom) : pick[$urandom_range(0, 5)];
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 11) == 0);
      h = ($urandom_range(0, 11) == 0);
      b = ($urandom_range(0, 11) == 0);
      c = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 9) == 0);
      model_step(r, s, h, b, c, f);
      prev_bcd = bus.timer_bcd;
      cyc(r, s, h, b, c, f);
      chk("rnd_state", bus.state, 16'(ms));
      chk("rnd_num", bus.stage_num, 16'(mn));
      chk("rnd_enter", bus.state_enter, 16'(me));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
